darkbus_ifetch: RTL

- Instruction-fetch initiator on darkbus.
- Issues sequential word reads to a darkbus responder (boot ROM, memory), buffers returned words in a small prefetch FIFO and hands them to the core decode stage with a valid/ready handshake.
- Supports a redirect input (branch/jump/trap) that flushes buffered and in-flight fetches.

---
 rtl/darkbus_pkg.sv | 9 +
 rtl/darkbus_if.sv | 10 +
 rtl/darkbus_ifetch_fifo.sv | 45 ++++
 rtl/darkbus_ifetch.sv | 76 +++++++
 4 files changed

// File: rtl/darkbus_pkg.sv
// darkbus_pkg: shared types and constants for the darkbus instruction fetcher
package darkbus_pkg;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  typedef enum logic [1:0] {BOOT, RUN, DRAIN} ifetch_state_t;
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } ifetch_entry_t;
endpackage

// File: rtl/darkbus_if.sv
// darkbus: single-cycle read bus; prod is the initiator, cons the responder
interface darkbus;
  logic [31:0] addr;
  logic        en;
  logic        rw;
  logic [31:0] data;
  logic        valid;
  modport prod(output addr, en, rw, input data, valid);
  modport cons(input addr, en, rw, output data, valid);
endinterface

// File: rtl/darkbus_ifetch_fifo.sv
// darkbus_ifetch_fifo: prefetch FIFO of fetched words with flush
module darkbus_ifetch_fifo
  import darkbus_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  ifetch_entry_t i_din,
  output ifetch_entry_t o_dout,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);
  ifetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign o_count = r_cnt;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_dout  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      r_rd  <= r_rd + AW'(w_pop);
      r_wr  <= r_wr + AW'(w_push);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push && !i_flush) r_mem[r_wr] <= i_din;
endmodule

// File: rtl/darkbus_ifetch.sv
// darkbus_ifetch: sequential instruction fetch over darkbus with prefetch FIFO and redirect flush.
// Define DARKBUS_IFETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module darkbus_ifetch
  import darkbus_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        XCLK,
  input  logic        XRES,
  darkbus.prod        BUS,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam ifetch_entry_t IDLE_ENTRY = '{data: NOP_INSN, pc: RESET_PC};
  ifetch_state_t r_state, w_state_nx;
  logic [31:0]   r_fetch_pc, w_fetch_pc_nx;
  logic          r_out, w_out_nx;
  logic          w_credit, w_issue, w_accept, w_byp, w_push, w_pop, w_full, w_empty;
  logic [AW:0]   w_count;
  ifetch_entry_t w_rsp, w_head, w_inst;
  always_ff @(posedge XCLK or posedge XRES)
    if (XRES) begin
      r_state    <= BOOT;
      r_fetch_pc <= RESET_PC;
      r_out      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_fetch_pc <= w_fetch_pc_nx;
      r_out      <= w_out_nx;
    end
  // A response always belongs to the request issued last cycle, whose pc is fetch_pc-4
  always_comb begin
    w_credit      = (w_count + (AW+1)'(r_out)) < (AW+1)'(FIFO_DEPTH);
    w_issue       = r_state == RUN && !redir_valid && w_credit;
    w_accept      = r_state == RUN && r_out && BUS.valid && !redir_valid;
    w_state_nx    = r_state == BOOT ? RUN :
                    r_state == RUN  ? (redir_valid && r_out ? DRAIN : RUN) :
                    (r_out && !BUS.valid ? DRAIN : RUN);
    w_fetch_pc_nx = redir_valid ? redir_pc & ~32'd3 : w_issue ? r_fetch_pc + 32'd4 : r_fetch_pc;
    w_out_nx      = w_issue || (r_out && !BUS.valid);
    w_rsp.data    = BUS.data;
    w_rsp.pc      = r_fetch_pc - 32'd4;
`ifdef DARKBUS_IFETCH_BYPASS_EN
    w_byp         = w_accept && w_empty;
`else
    w_byp         = 1'b0;
`endif
    w_push        = w_accept && !w_full && !(w_byp && inst_ready);
    w_pop         = !w_empty && inst_ready;
    w_inst        = w_byp ? w_rsp : w_empty ? IDLE_ENTRY : w_head;
  end
  darkbus_ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (XCLK),
    .rst    (XRES),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(redir_valid),
    .i_din  (w_rsp),
    .o_dout (w_head),
    .o_count(w_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign BUS.en     = w_issue;
  assign BUS.addr   = r_fetch_pc;
  assign BUS.rw     = 1'b0;
  assign inst_valid = !w_empty || w_byp;
  assign inst_data  = w_inst.data;
  assign inst_pc    = w_inst.pc;
endmodule
